// File: rtl/dmem_subword_if.sv
// Request/response bundle between the MEM stage (master) and dmem_subword (slave).
// Latency: n/a (wires only). Backpressure: none; the memory accepts a request every cycle.
interface dmem_subword_if;
  logic [1:0]  memwrite;
  logic        memread;
  logic        hlaf;
  logic        b;
  logic        bunsigned;
  logic [31:0] adr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        rd_valid;
  logic        fault;

  modport master (
    output memwrite, memread, hlaf, b, bunsigned, adr, wd,
    input  rd, rd_valid, fault
  );

  modport slave (
    input  memwrite, memread, hlaf, b, bunsigned, adr, wd,
    output rd, rd_valid, fault
  );
endinterface

// File: rtl/dmem_subword.sv
// Byte/half/word data memory with extended, registered loads; DMEM_MISALIGN_TRAP_EN enables misalignment trapping.
// Latency: load result in rd one cycle after the request; stores commit at the request edge.
// Backpressure: none; one store and/or one load accepted every cycle.
module dmem_subword #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         reset,
  dmem_subword_if.slave bus
);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] idx;
  logic          unused_hi;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic [31:0]   rword;
  logic [7:0]    bsel;
  logic [15:0]   hsel;
  logic [31:0]   ld_data;
  logic [31:0]   rd_q;
  logic          rd_valid_q;
  logic          st_block;
  logic          ld_zero;

  // Upper address bits are dropped so accesses wrap within the array.
  assign idx       = bus.adr[AW+1:2];
  assign unused_hi = ^bus.adr[31:AW+2];

`ifdef DMEM_MISALIGN_TRAP_EN
  logic fault_q;

  assign st_block = ((bus.memwrite == 2'b01) && (bus.adr[1:0] != 2'b00)) ||
                    ((bus.memwrite == 2'b10) && bus.adr[0]);
  assign ld_zero  = !bus.b && (bus.hlaf ? bus.adr[0] : (bus.adr[1:0] != 2'b00));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      fault_q <= 1'b0;
    else if (st_block || (bus.memread && ld_zero))
      fault_q <= 1'b1;
  end
  assign bus.fault = fault_q;
`else
  // Lane selection below only looks at adr[1] for halves and ignores adr[1:0]
  // for words, which is exactly the forced-alignment behaviour.
  assign st_block  = 1'b0;
  assign ld_zero   = 1'b0;
  assign bus.fault = 1'b0;
`endif

  always_comb begin
    be    = 4'b0000;
    wdata = bus.wd;
    case (bus.memwrite)
      2'b01: be = 4'b1111;
      2'b10: begin
        be    = bus.adr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{bus.wd[15:0]}};
      end
      2'b11: begin
        be    = 4'b0001 << bus.adr[1:0];
        wdata = {4{bus.wd[7:0]}};
      end
      default: be = 4'b0000;
    endcase
    if (st_block)
      be = 4'b0000;
  end

  // Contents are deliberately not reset; stores are simply gated while reset is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i])
          mem[idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rword = mem[idx];
  assign bsel  = rword[{bus.adr[1:0], 3'b000} +: 8];
  assign hsel  = bus.adr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld_data = rword;
    if (bus.b)
      ld_data = {{24{~bus.bunsigned & bsel[7]}}, bsel};
    else if (bus.hlaf)
      ld_data = {{16{~bus.bunsigned & hsel[15]}}, hsel};
    if (ld_zero)
      ld_data = 32'h0;
  end

  // A same-edge store is non-blocking, so the load sees pre-store contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q       <= 32'h0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= bus.memread;
      if (bus.memread)
        rd_q <= ld_data;
    end
  end

  assign bus.rd       = rd_q;
  assign bus.rd_valid = rd_valid_q;

endmodule
